fluorescence_acquisition_sequencer: RTL and testbench

//  Runs one photon-counting acquisition run for the fluorescence front end.
//  - Drives the light source square wave.
//  - Blanks PMT pulses for a settling window after each light edge.
//  - Sorts the remaining pulses into bright and dark accumulators over whole frames.
//  - Hands each frame result to the readout logic through a valid/ready handshake.

---
 rtl/fluorescence_acquisition_sequencer.sv | 264 ++++++++++++++++++++++++++
 tb/tb_fluorescence_acquisition_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fluorescence_acquisition_sequencer.sv
// Light-source sequencer and gated photon counter for the fluorescence front end.
// Optional blanked-pulse counter and port: define BLANKED_COUNT_EN.
module fluorescence_acquisition_sequencer #(
  parameter int CNT_W   = 32,
  parameter int TIMER_W = 32,
  parameter int FRAME_W = 16
) (
  input  logic               clock_50_mhz,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [TIMER_W-1:0] half_period_cfg,
  input  logic [TIMER_W-1:0] blank_cfg,
  input  logic [FRAME_W-1:0] period_cfg,
  input  logic [FRAME_W-1:0] frames_cfg,
  input  logic               pulse_in,
  output logic               light_source_pin,
  output logic               busy,
  output logic               result_valid,
  input  logic               result_ready,
  output logic [CNT_W-1:0]   bright_count,
  output logic [CNT_W-1:0]   dark_count,
`ifdef BLANKED_COUNT_EN
  output logic [CNT_W-1:0]   blanked_count,
`endif
  output logic               overrun,
  output logic               done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FEND = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0]   CNT_MAX = '1;
  localparam logic [CNT_W-1:0]   CNT_0   = '0;
  localparam logic [TIMER_W-1:0] T_0     = '0;
  localparam logic [TIMER_W-1:0] T_1     = 1;
  localparam logic [TIMER_W-1:0] T_2     = 2;
  localparam logic [FRAME_W-1:0] F_0     = '0;
  localparam logic [FRAME_W-1:0] F_1     = 1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  state_e             state_q, state_d;
  logic               light_q, light_d;
  logic [TIMER_W-1:0] t_q, t_d;
  logic [TIMER_W-1:0] h_q, h_d;
  logic [TIMER_W-1:0] blank_q, blank_d;
  logic [FRAME_W-1:0] per_q, per_d;
  logic [FRAME_W-1:0] frames_q, frames_d;
  logic [FRAME_W-1:0] per_cnt_q, per_cnt_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]   bright_acc_q, bright_acc_d;
  logic [CNT_W-1:0]   dark_acc_q, dark_acc_d;
  logic [CNT_W-1:0]   bright_res_q, bright_res_d;
  logic [CNT_W-1:0]   dark_res_q, dark_res_d;
  logic               valid_q, valid_d;
  logic               overrun_q, overrun_d;
  logic               done_q, done_d;
`ifdef BLANKED_COUNT_EN
  logic [CNT_W-1:0]   blank_acc_q, blank_acc_d;
  logic [CNT_W-1:0]   blank_res_q, blank_res_d;
`endif

  logic               last_t;
  logic               frame_last;
  logic               counted;
  logic [FRAME_W-1:0] frame_nxt;

  assign last_t     = (t_q == h_q - T_1);
  assign frame_last = last_t && !light_q && (per_cnt_q == per_q - F_1);
  assign counted    = pulse_in && (t_q >= blank_q);
  assign frame_nxt  = frame_cnt_q + F_1;

  // Next-state, timing, accumulation and result handshake
  always_comb begin
    state_d      = state_q;
    light_d      = light_q;
    t_d          = t_q;
    h_d          = h_q;
    blank_d      = blank_q;
    per_d        = per_q;
    frames_d     = frames_q;
    per_cnt_d    = per_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    bright_acc_d = bright_acc_q;
    dark_acc_d   = dark_acc_q;
    bright_res_d = bright_res_q;
    dark_res_d   = dark_res_q;
    valid_d      = valid_q;
    overrun_d    = overrun_q;
    done_d       = 1'b0;
`ifdef BLANKED_COUNT_EN
    blank_acc_d  = blank_acc_q;
    blank_res_d  = blank_res_q;
`endif

    if (valid_q && result_ready) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d      = S_RUN;
          light_d      = 1'b1;
          t_d          = T_0;
          h_d          = (half_period_cfg < T_2) ? T_2 : half_period_cfg;
          blank_d      = blank_cfg;
          per_d        = (period_cfg == F_0) ? F_1 : period_cfg;
          frames_d     = frames_cfg;
          per_cnt_d    = F_0;
          frame_cnt_d  = F_0;
          bright_acc_d = CNT_0;
          dark_acc_d   = CNT_0;
          overrun_d    = 1'b0;
`ifdef BLANKED_COUNT_EN
          blank_acc_d  = CNT_0;
`endif
        end
      end
      S_RUN: begin
        if (counted) begin
          if (light_q) begin
            bright_acc_d = sat_inc(bright_acc_q);
          end else begin
            dark_acc_d = sat_inc(dark_acc_q);
          end
        end
`ifdef BLANKED_COUNT_EN
        if (pulse_in && !counted) begin
          blank_acc_d = sat_inc(blank_acc_q);
        end
`endif
        if (last_t) begin
          t_d     = T_0;
          light_d = !light_q;
          if (!light_q) begin
            if (frame_last) begin
              state_d = S_FEND;
            end else begin
              per_cnt_d = per_cnt_q + F_1;
            end
          end
        end else begin
          t_d = t_q + T_1;
        end
      end
      S_FEND: begin
        if (!valid_q) begin
          bright_res_d = bright_acc_q;
          dark_res_d   = dark_acc_q;
          valid_d      = 1'b1;
`ifdef BLANKED_COUNT_EN
          blank_res_d  = blank_acc_q;
`endif
        end else begin
          overrun_d = 1'b1;
        end
        bright_acc_d = CNT_0;
        dark_acc_d   = CNT_0;
`ifdef BLANKED_COUNT_EN
        blank_acc_d  = CNT_0;
`endif
        per_cnt_d    = F_0;
        frame_cnt_d  = frame_nxt;
        t_d          = T_0;
        if ((frames_q != F_0) && (frame_nxt == frames_q)) begin
          state_d = S_IDLE;
          light_d = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = S_RUN;
          light_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides everything in an active run; overrun survives
    if (abort && (state_q != S_IDLE)) begin
      state_d      = S_IDLE;
      light_d      = 1'b0;
      t_d          = T_0;
      per_cnt_d    = F_0;
      frame_cnt_d  = F_0;
      bright_acc_d = CNT_0;
      dark_acc_d   = CNT_0;
      bright_res_d = CNT_0;
      dark_res_d   = CNT_0;
      valid_d      = 1'b0;
      done_d       = 1'b0;
`ifdef BLANKED_COUNT_EN
      blank_acc_d  = CNT_0;
      blank_res_d  = CNT_0;
`endif
    end
  end

  // State and datapath registers
  always_ff @(posedge clock_50_mhz) begin
    if (reset) begin
      state_q      <= S_IDLE;
      light_q      <= 1'b0;
      t_q          <= T_0;
      h_q          <= T_0;
      blank_q      <= T_0;
      per_q        <= F_0;
      frames_q     <= F_0;
      per_cnt_q    <= F_0;
      frame_cnt_q  <= F_0;
      bright_acc_q <= CNT_0;
      dark_acc_q   <= CNT_0;
      bright_res_q <= CNT_0;
      dark_res_q   <= CNT_0;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
      done_q       <= 1'b0;
`ifdef BLANKED_COUNT_EN
      blank_acc_q  <= CNT_0;
      blank_res_q  <= CNT_0;
`endif
    end else begin
      state_q      <= state_d;
      light_q      <= light_d;
      t_q          <= t_d;
      h_q          <= h_d;
      blank_q      <= blank_d;
      per_q        <= per_d;
      frames_q     <= frames_d;
      per_cnt_q    <= per_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      bright_acc_q <= bright_acc_d;
      dark_acc_q   <= dark_acc_d;
      bright_res_q <= bright_res_d;
      dark_res_q   <= dark_res_d;
      valid_q      <= valid_d;
      overrun_q    <= overrun_d;
      done_q       <= done_d;
`ifdef BLANKED_COUNT_EN
      blank_acc_q  <= blank_acc_d;
      blank_res_q  <= blank_res_d;
`endif
    end
  end

  assign light_source_pin = light_q;
  assign busy             = (state_q != S_IDLE);
  assign result_valid     = valid_q;
  assign bright_count     = bright_res_q;
  assign dark_count       = dark_res_q;
  assign overrun          = overrun_q;
  assign done             = done_q;
`ifdef BLANKED_COUNT_EN
  assign blanked_count    = blank_res_q;
`endif

endmodule

// File: tb/tb_fluorescence_acquisition_sequencer.sv
// Directed bench for fluorescence_acquisition_sequencer.
// A second instance with CNT_W=4 shares the stimulus to exercise saturation.
module tb_fluorescence_acquisition_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [31:0] half_period_cfg;
  logic [31:0] blank_cfg;
  logic [15:0] period_cfg;
  logic [15:0] frames_cfg;
  logic        pulse_in;
  logic        result_ready;

  logic        light, busy, valid, overrun, done;
  logic [31:0] bright, dark;
  logic        s_light, s_busy, s_valid, s_overrun, s_done;
  logic [3:0]  s_bright, s_dark;
`ifdef BLANKED_COUNT_EN
  logic [31:0] blanked;
  logic [3:0]  s_blanked;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #10 clk = ~clk;

  fluorescence_acquisition_sequencer dut (
    .clock_50_mhz    (clk),
    .reset           (reset),
    .start           (start),
    .abort           (abort),
    .half_period_cfg (half_period_cfg),
    .blank_cfg       (blank_cfg),
    .period_cfg      (period_cfg),
    .frames_cfg      (frames_cfg),
    .pulse_in        (pulse_in),
    .light_source_pin(light),
    .busy            (busy),
    .result_valid    (valid),
    .result_ready    (result_ready),
    .bright_count    (bright),
    .dark_count      (dark),
`ifdef BLANKED_COUNT_EN
    .blanked_count   (blanked),
`endif
    .overrun         (overrun),
    .done            (done)
  );

  fluorescence_acquisition_sequencer #(.CNT_W(4)) u_sat (
    .clock_50_mhz    (clk),
    .reset           (reset),
    .start           (start),
    .abort           (abort),
    .half_period_cfg (half_period_cfg),
    .blank_cfg       (blank_cfg),
    .period_cfg      (period_cfg),
    .frames_cfg      (frames_cfg),
    .pulse_in        (pulse_in),
    .light_source_pin(s_light),
    .busy            (s_busy),
    .result_valid    (s_valid),
    .result_ready    (result_ready),
    .bright_count    (s_bright),
    .dark_count      (s_dark),
`ifdef BLANKED_COUNT_EN
    .blanked_count   (s_blanked),
`endif
    .overrun         (s_overrun),
    .done            (s_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    half_period_cfg = 32'd10;
    blank_cfg = 32'd2;
    period_cfg = 16'd3;
    frames_cfg = 16'd1;
    pulse_in = 1'b0;
    result_ready = 1'b0;
    steps(3);
    reset = 1'b0;
    step();

    // reset state
    chk("rst_busy", busy, 0);
    chk("rst_light", light, 0);
    chk("rst_valid", valid, 0);
    chk("rst_bright", bright, 0);
    chk("rst_dark", dark, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_done", done, 0);

    // test 1: pulse every cycle, H=10 blank=2 period=3 frames=1
    pulse_in = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t1_light_on", light, 1);
    chk("t1_busy", busy, 1);
    half_period_cfg = 32'd3;
    period_cfg = 16'd1;
    steps(60);
    chk("t1_valid_fend", valid, 0);
    chk("t1_busy_fend", busy, 1);
    step();
    chk("t1_valid", valid, 1);
    chk("t1_bright", bright, 24);
    chk("t1_dark", dark, 24);
    chk("t1_done", done, 1);
    chk("t1_light_off", light, 0);
    chk("t1_busy_off", busy, 0);
    chk("t1_overrun", overrun, 0);
    chk("t1_sat_bright", {28'd0, s_bright}, 15);
    chk("t1_sat_dark", {28'd0, s_dark}, 15);
`ifdef BLANKED_COUNT_EN
    chk("t1_blanked", blanked, 12);
`endif
    pulse_in = 1'b0;
    result_ready = 1'b1;
    step();
    chk("t1_valid_drop", valid, 0);
    chk("t1_done_pulse", done, 0);
    result_ready = 1'b0;

    // test 2: pulses at t==9 of bright phases plus one at t==1
    half_period_cfg = 32'd10;
    period_cfg = 16'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 60; k++) begin
      pulse_in = ((k % 10 == 9) && ((k / 10) % 2 == 0)) || (k == 1);
      step();
    end
    pulse_in = 1'b0;
    step();
    chk("t2_valid", valid, 1);
    chk("t2_bright", bright, 3);
    chk("t2_dark", dark, 0);
    chk("t2_done", done, 1);
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;

    // test 3: continuous run, readout stalled -> overrun
    period_cfg = 16'd1;
    frames_cfg = 16'd0;
    pulse_in = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
`ifdef BLANKED_COUNT_EN
    steps(20);
    step();
    chk("t3_blanked", blanked, 4);
`else
    steps(21);
`endif
    pulse_in = 1'b0;
    chk("t3_valid1", valid, 1);
    chk("t3_bright1", bright, 8);
    chk("t3_dark1", dark, 8);
    chk("t3_ovr1", overrun, 0);
    chk("t3_busy", busy, 1);
    chk("t3_light", light, 1);
    steps(21);
    chk("t3_ovr2", overrun, 1);
    chk("t3_valid2", valid, 1);
    chk("t3_keep", bright, 8);
    result_ready = 1'b1;
    step();
    chk("t3_valid_drop", valid, 0);
    chk("t3_still_busy", busy, 1);
    result_ready = 1'b0;

    // test 4: third frame result, then abort mid-frame
    pulse_in = 1'b1;
    steps(20);
    chk("t4_valid", valid, 1);
    chk("t4_bright", bright, 8);
    chk("t4_dark", dark, 8);
    steps(5);
    abort = 1'b1;
    step();
    abort = 1'b0;
    pulse_in = 1'b0;
    chk("t4_busy", busy, 0);
    chk("t4_light", light, 0);
    chk("t4_valid_clr", valid, 0);
    chk("t4_bright_clr", bright, 0);
    chk("t4_dark_clr", dark, 0);
    chk("t4_no_done", done, 0);
    chk("t4_ovr_kept", overrun, 1);
    step();
    chk("t4_no_done2", done, 0);

    // test 5: start and abort together stay idle
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk("t5_idle", busy, 0);
    chk("t5_ovr", overrun, 1);

    // test 6: half period 0 acts as 2
    half_period_cfg = 32'd0;
    blank_cfg = 32'd0;
    period_cfg = 16'd1;
    frames_cfg = 16'd1;
    pulse_in = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t6_ovr_clr", overrun, 0);
    chk("t6_light_on", light, 1);
    steps(2);
    chk("t6_light_dark", light, 0);
    steps(2);
    chk("t6_fend_busy", busy, 1);
    step();
    pulse_in = 1'b0;
    chk("t6_valid", valid, 1);
    chk("t6_bright", bright, 2);
    chk("t6_dark", dark, 2);
    chk("t6_done", done, 1);
    chk("t6_sat_bright", {28'd0, s_bright}, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
